// File: rtl/cic_comb_dec.sv
// CIC decimator back end: rate-R sample selection followed by N comb stages and output quantization.
// Define CIC_COMB_ROUND_EN to round half-up with positive saturation instead of truncating.
module cic_comb_dec #(
  parameter int Win  = 38,
  parameter int Wout = 16,
  parameter int R    = 8,
  parameter int N    = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic signed [Win-1:0]  data_in,
  input  logic                   val_in,
  output logic signed [Wout-1:0] data_out,
  output logic                   val_out
);

  localparam int CW = (R > 1) ? $clog2(R) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(R - 1);

  logic [CW-1:0]          cnt;
  logic                   keep;
  logic signed [Win-1:0]  stg [0:N];
  logic signed [Win-1:0]  dly [1:N];
  logic [N:0]             vld;
  logic signed [Wout-1:0] q;

  assign keep = val_in && (cnt == '0);

  // Delay registers only move on stage-valid cycles, so gaps in val_in leave the combs untouched.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= '0;
      vld      <= '0;
      data_out <= '0;
      val_out  <= 1'b0;
      for (int k = 0; k <= N; k++) stg[k] <= '0;
      for (int k = 1; k <= N; k++) dly[k] <= '0;
    end else begin
      if (val_in) cnt <= (cnt == CNT_LAST) ? '0 : cnt + CW'(1);
      vld <= {vld[N-1:0], keep};
      if (keep) stg[0] <= data_in;
      for (int k = 1; k <= N; k++) begin
        if (vld[k-1]) begin
          stg[k] <= stg[k-1] - dly[k];
          dly[k] <= stg[k-1];
        end
      end
      val_out <= vld[N];
      if (vld[N]) data_out <= q;
    end
  end

`ifdef CIC_COMB_ROUND_EN
  generate
    if (Win > Wout) begin : g_round
      localparam int S = Win - Wout;
      localparam logic signed [Win-1:0] HALF = {{(Win-1){1'b0}}, 1'b1} << (S - 1);
      logic signed [Win-1:0] sum;
      assign sum = stg[N] + HALF;
      // A non-negative value that turns negative after adding HALF has overflowed.
      assign q = (!stg[N][Win-1] && sum[Win-1]) ? {1'b0, {(Wout-1){1'b1}}}
                                                : Wout'(sum >>> S);
    end else begin : g_ident
      assign q = Wout'(stg[N]);
    end
  endgenerate
`else
  assign q = Wout'(stg[N] >>> (Win - Wout));
`endif

endmodule

// File: tb/tb_cic_comb_dec.sv
// Bench for cic_comb_dec: three parameterizations driven together, checked against an
// N-th-difference reference model of the decimated sample stream.
module tb_cic_comb_dec;
  localparam int NI = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [37:0] din_a;
  logic [15:0] din_b;
  logic [7:0]  din_c;
  logic        val_a, val_b, val_c;
  logic [15:0] dout_a;
  logic [7:0]  dout_b, dout_c;
  logic        vout_a, vout_b, vout_c;

  cic_comb_dec dut_a (
    .clk(clk), .rst(rst), .data_in(din_a), .val_in(val_a),
    .data_out(dout_a), .val_out(vout_a)
  );

  cic_comb_dec #(.Win(16), .Wout(8), .R(1), .N(1)) dut_b (
    .clk(clk), .rst(rst), .data_in(din_b), .val_in(val_b),
    .data_out(dout_b), .val_out(vout_b)
  );

  cic_comb_dec #(.Win(8), .Wout(8), .R(3), .N(2)) dut_c (
    .clk(clk), .rst(rst), .data_in(din_c), .val_in(val_c),
    .data_out(dout_c), .val_out(vout_c)
  );

  int     checks = 0;
  int     failures = 0;
  longint cyc = 0;

  task automatic chk_val(string tag, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int p_win(int i);
    case (i) 0: return 38; 1: return 16; default: return 8; endcase
  endfunction
  function automatic int p_wout(int i);
    case (i) 0: return 16; 1: return 8; default: return 8; endcase
  endfunction
  function automatic int p_r(int i);
    case (i) 0: return 8; 1: return 1; default: return 3; endcase
  endfunction
  function automatic int p_n(int i);
    case (i) 0: return 3; 1: return 1; default: return 2; endcase
  endfunction

  // Reference: output m is the N-th backward difference of kept samples (zeros before reset).
  int     m_cnt [NI];
  longint hist  [NI][7];
  longint exp_d [NI];
  longint due_q [NI][$];
  longint val_q [NI][$];

  function automatic longint binom(int n, int k);
    longint c = 1;
    for (int j = 0; j < k; j++) c = c * (n - j) / (j + 1);
    return c;
  endfunction

  function automatic longint quant(int i, longint y);
    int w, wo, s;
    longint one, ys, q, t;
    w = p_win(i); wo = p_wout(i); s = w - wo; one = 1;
    ys = y;
    if (((y >> (w - 1)) & one) != 0) ys = y - (one << w);
    q = ys >>> s;
`ifdef CIC_COMB_ROUND_EN
    if (s > 0) begin
      t = ys + (one << (s - 1));
      if (t > (one << (w - 1)) - 1) q = (one << (wo - 1)) - 1;
      else q = t >>> s;
    end
`else
    t = 0;
`endif
    return q & ((one << wo) - 1);
  endfunction

  task automatic model_edge(int i, logic v, longint d);
    longint one, mask, acc, term;
    one = 1;
    mask = (one << p_win(i)) - 1;
    if (rst) begin
      m_cnt[i] = 0;
      for (int j = 0; j < 7; j++) hist[i][j] = 0;
      exp_d[i] = 0;
      due_q[i].delete();
      val_q[i].delete();
    end else if (v) begin
      if (m_cnt[i] == 0) begin
        for (int j = 6; j > 0; j--) hist[i][j] = hist[i][j-1];
        hist[i][0] = d & mask;
        acc = 0;
        for (int j = 0; j <= p_n(i); j++) begin
          term = binom(p_n(i), j) * hist[i][j];
          acc = (j % 2 == 1) ? acc - term : acc + term;
        end
        due_q[i].push_back(cyc + p_n(i) + 1);
        val_q[i].push_back(quant(i, acc & mask));
      end
      m_cnt[i] = (m_cnt[i] + 1) % p_r(i);
    end
  endtask

  task automatic check_inst(int i, logic vout, logic [15:0] dout);
    logic ev;
    ev = 1'b0;
    if (due_q[i].size() > 0 && due_q[i][0] == cyc) begin
      ev = 1'b1;
      exp_d[i] = val_q[i].pop_front();
      void'(due_q[i].pop_front());
    end
    chk_val($sformatf("val_out[%0d]", i), 64'(vout), 64'(ev));
    chk_val($sformatf("data_out[%0d]", i), 64'(dout), 64'(exp_d[i]));
  endtask

  task automatic step();
    @(posedge clk);
    cyc++;
    model_edge(0, val_a, longint'(din_a));
    model_edge(1, val_b, longint'(din_b));
    model_edge(2, val_c, longint'(din_c));
    #1;
    check_inst(0, vout_a, dout_a);
    check_inst(1, vout_b, 16'(dout_b));
    check_inst(2, vout_c, 16'(dout_c));
  endtask

  task automatic rand_ac(logic force_val);
    val_a = force_val || ($urandom_range(0, 3) != 0);
    val_c = force_val || ($urandom_range(0, 3) != 0);
    din_a = 38'({$urandom(), $urandom()});
    din_c = 8'($urandom());
  endtask

  task automatic directed_b(string tag, logic [15:0] a, logic [15:0] b, logic [7:0] expv);
    int seen;
    seen = 0;
    rst = 1'b1; val_b = 1'b0; rand_ac(1'b0); step();
    rst = 1'b0;
    val_b = 1'b1; din_b = a; rand_ac(1'b0); step();
    din_b = b; rand_ac(1'b0); step();
    val_b = 1'b0;
    for (int t = 0; t < 6; t++) begin
      rand_ac(1'b0);
      step();
      if (vout_b) begin
        seen++;
        if (seen == 2) chk_val(tag, 64'(dout_b), 64'(expv));
      end
    end
    chk_val({tag, "_strobes"}, 64'(seen), 64'd2);
  endtask

  initial begin
    logic [37:0] smp;
    int found;
    rst = 1'b1;
    val_a = 1'b0; val_b = 1'b0; val_c = 1'b0;
    din_a = '0; din_b = '0; din_c = '0;
    step(); step();
    chk_val("rst_vout_a", 64'(vout_a), 64'd0);
    chk_val("rst_dout_a", 64'(dout_a), 64'd0);
    chk_val("rst_dout_b", 64'(dout_b), 64'd0);
    rst = 1'b0;

    // continuous valid: every sample kept at R=1
    for (int t = 0; t < 200; t++) begin
      rand_ac(1'b1);
      val_b = 1'b1;
      din_b = 16'($urandom());
      step();
    end

`ifdef CIC_COMB_ROUND_EN
    directed_b("quant_0180", 16'h0000, 16'h0180, 8'h02);
`else
    directed_b("quant_0180", 16'h0000, 16'h0180, 8'h01);
`endif
    directed_b("sat_7fc0", 16'h0000, 16'h7FC0, 8'h7F);
    directed_b("wrap_8000", 16'h7F00, 16'h8000, 8'h01);

    // mid-operation reset with samples in flight
    for (int t = 0; t < 5; t++) begin
      rand_ac(1'b1); val_b = 1'b1; din_b = 16'($urandom()); step();
    end
    rst = 1'b1; step();
    chk_val("midrst_vout_a", 64'(vout_a), 64'd0);
    chk_val("midrst_dout_a", 64'(dout_a), 64'd0);
    chk_val("midrst_vout_c", 64'(vout_c), 64'd0);
    rst = 1'b0;
    smp = 38'({$urandom(), $urandom()});
    val_a = 1'b1; din_a = smp; val_b = 1'b0; val_c = 1'b0;
    step();
    val_a = 1'b0;
    found = 0;
    for (int t = 0; t < 8; t++) begin
      step();
      if (vout_a) begin
        found++;
        chk_val("midrst_first", 64'(dout_a), 64'(smp[37:22]));
      end
    end
    chk_val("midrst_strobes", 64'(found), 64'd1);

    // random gaps, occasional resets
    for (int t = 0; t < 1500; t++) begin
      rst = ($urandom_range(0, 99) == 0);
      rand_ac(1'b0);
      val_b = ($urandom_range(0, 2) != 0);
      din_b = 16'($urandom());
      step();
    end
    rst = 1'b0; val_a = 1'b0; val_b = 1'b0; val_c = 1'b0;
    for (int t = 0; t < 8; t++) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
